multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multicycle control FSM for the PikaRISC core.
- Consumes the per-instruction class flags from the decode stage and sequences instruction fetch, execute, data memory, writeback, call/return stack traffic and PC update.
- Sits between the instruction register/decoder and the datapath enables (PC, register file, flags, SP, memory ports).
- Also provides bus-timeout fault handling and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16, maximum wait cycles for a memory ready before fault (must be ≥2).
- RET_CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- reset_n  in  1  synchronous, active-low reset
- is_alu_op, is_cmp_op, is_jmp_op, is_ld_op, is_str_op, is_call_op, is_ret_op  in  1 each  decode class flags for the current IR
- cond_true  in  1  jump condition evaluated against the flags register
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid
- ir_write  out  1  latch instruction register
- dmem_req  out  1  data memory request
- dmem_we  out  1  data write enable, valid with dmem_req
- dmem_ready  in  1  data access complete
- dmem_addr_sel  out  1  data address source: 0 = ALU result, 1 = SP
- pc_write  out  1  PC update strobe
- pc_src  out  2  PC source: 0 = PC+1, 1 = branch/call target, 2 = memory data
- reg_write  out  1  register file write strobe
- wb_sel  out  1  writeback source: 0 = ALU, 1 = memory
- flag_write  out  1  flags register update
- sp_dec, sp_inc  out  1 each  stack pointer adjust strobes
- illegal_op, bus_error  out  1 each  single-cycle event pulses
- halted  out  1  high in FAULT
- state  out  3  current state encoding, for debug
- retired_cnt  out  RET_CNT_W  retired-instruction count

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7. Encoding is fixed.
- Reset (reset_n=0 at a clk edge):
  - state=FETCH, wait counter=0, retired_cnt=0.
  - All strobes/requests 0; pc_src=0, wb_sel=0, dmem_addr_sel=0.
  - Reset mid-transaction drops imem_req/dmem_req in the next cycle. No write strobe is issued.
- All outputs are combinational from state plus inputs. Only state, the counters and a latched class register (captured in DECODE) are flops.
- FETCH:
  - imem_req=1 until imem_ready.
  - In the cycle imem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE:
  - Latch the class flags and go to EXEC.
  - If no flag is set: illegal_op pulse, retire, go to FETCH.
  - If more than one flag is set, priority is ret > call > str > ld > jmp > cmp > alu.
- EXEC, by class:
  - alu: flag_write=1, then WB.
  - cmp: flag_write=1, retire, then FETCH.
  - jmp: pc_write=cond_true, pc_src=1, retire, then FETCH.
  - ld/str: go to MEM with dmem_addr_sel=0.
  - call: sp_dec=1, then MEM.
  - ret: go to MEM with dmem_addr_sel=1.
- MEM:
  - dmem_req=1 held until dmem_ready.
  - dmem_we=1 for str/call. dmem_addr_sel=1 for call/ret.
  - On dmem_ready:
    - str: retire, then FETCH.
    - call: pc_write=1, pc_src=1, retire, then FETCH.
    - ld/ret: go to WB.
- WB:
  - alu: reg_write=1, wb_sel=0.
  - ld: reg_write=1, wb_sel=1.
  - ret: pc_write=1, pc_src=2, sp_inc=1.
  - Retire, then FETCH.
- Timeout:
  - The wait counter clears on entering FETCH/MEM and increments each cycle the request is held without ready.
  - When the counter reaches MEM_TIMEOUT-1 with ready still 0: bus_error pulse, request drops, go to FAULT. No strobes are issued.
  - A ready arriving in that same cycle wins: normal completion, no fault.
- FAULT: all strobes 0, halted=1. Exits only via reset.
- Retire: retired_cnt += 1 (wrapping modulo 2^RET_CNT_W) in the final cycle of each instruction, including illegal ones.
- Minimum latencies, in cycles, with ready returned in the first cycle:
  - cmp/jmp: 3
  - alu/str/call: 4
  - ld/ret: 5

Decomposition:
- Shared package/defines: state encodings, PC_SRC_INC/TARGET/MEM, WB_ALU/MEM, ADDR_ALU/SP constants. These sit alongside the existing opcode defines.
- One natural sub-module: mem_wait_timer (wait counter + timeout compare), instantiated once and reused for the imem and dmem waits.

Test Plan:
- Reset, then alu instruction with imem_ready and dmem_ready tied 1 -> states 0,1,2,4,0. ir_write and pc_write(src 0) at cycle 0, flag_write at cycle 2, reg_write with wb_sel=0 at cycle 3, retired_cnt=1.
- ld with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles with we=0, addr_sel=0, then WB with reg_write and wb_sel=1. Total 8 cycles.
- jmp with cond_true=0, then jmp with cond_true=1 -> no EXEC pc_write on the first; on the second, pc_write=1 and pc_src=1 in EXEC. retired_cnt=2.
- call followed by ret -> call: sp_dec in EXEC, dmem_we=1 with addr_sel=1, then pc_write src 1. ret: dmem read with addr_sel=1, then WB pc_write src 2 with sp_inc.
- MEM_TIMEOUT=4, imem_ready held 0 -> bus_error pulse in the 4th FETCH cycle, state=7, halted=1 until reset. Ready arriving in the 4th cycle completes normally.
- All flags 0 -> illegal_op pulse in DECODE, no write strobes, returns to FETCH. Also: reset asserted during MEM with dmem_req high -> dmem_req=0 the next cycle, state=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the PikaRISC multicycle controller: FSM states,
// instruction classes and the datapath mux select constants.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_ALU,
    CLS_CMP,
    CLS_JMP,
    CLS_LD,
    CLS_STR,
    CLS_CALL,
    CLS_RET
  } op_class_t;

  localparam logic [1:0] PC_SRC_INC    = 2'd0;
  localparam logic [1:0] PC_SRC_TARGET = 2'd1;
  localparam logic [1:0] PC_SRC_MEM    = 2'd2;

  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;

  localparam logic ADDR_ALU = 1'b0;
  localparam logic ADDR_SP  = 1'b1;

  // Overlapping decode flags resolve as ret > call > str > ld > jmp > cmp > alu.
  function automatic op_class_t pick_class(input logic alu, input logic cmp,
                                           input logic jmp, input logic ld,
                                           input logic str, input logic call,
                                           input logic ret);
    if (ret)       return CLS_RET;
    else if (call) return CLS_CALL;
    else if (str)  return CLS_STR;
    else if (ld)   return CLS_LD;
    else if (jmp)  return CLS_JMP;
    else if (cmp)  return CLS_CMP;
    else if (alu)  return CLS_ALU;
    else           return CLS_NONE;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction and data memory handshake between the controller (master)
// and the memory system (slave).
interface multicycle_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;
  logic dmem_addr_sel;

  modport master (
    output imem_req, dmem_req, dmem_we, dmem_addr_sel,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we, dmem_addr_sel,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts consecutive cycles a memory request is held without ready and
// flags the cycle in which the wait budget is exhausted.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic waiting,
  output logic expired
);

  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] count;

  assign expired = waiting && (count == LAST);

  // Any cycle without a stalled request restarts the budget, so the count is
  // zero on entry to every wait state.
  always_ff @(posedge clk) begin
    if (!reset_n)
      count <= '0;
    else if (waiting && !expired)
      count <= count + 1'b1;
    else
      count <= '0;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the PikaRISC core: sequences fetch, execute,
// data memory, writeback and stack traffic, with bus-timeout fault handling.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  multicycle_ctrl_if.master    bus,
  input  logic                 is_alu_op,
  input  logic                 is_cmp_op,
  input  logic                 is_jmp_op,
  input  logic                 is_ld_op,
  input  logic                 is_str_op,
  input  logic                 is_call_op,
  input  logic                 is_ret_op,
  input  logic                 cond_true,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic                 wb_sel,
  output logic                 flag_write,
  output logic                 sp_dec,
  output logic                 sp_inc,
  output logic                 illegal_op,
  output logic                 bus_error,
  output logic                 halted,
  output logic [2:0]           state,
  output logic [RET_CNT_W-1:0] retired_cnt
);

  state_t    cur_state;
  op_class_t cls_q;
  op_class_t dec_cls;
  logic      waiting;
  logic      expired;
  logic      retire;

  assign dec_cls = pick_class(is_alu_op, is_cmp_op, is_jmp_op, is_ld_op,
                              is_str_op, is_call_op, is_ret_op);
  assign state   = cur_state;

  always_comb begin
    waiting = ((cur_state == ST_FETCH) && !bus.imem_ready) ||
              ((cur_state == ST_MEM)   && !bus.dmem_ready);
  end

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .waiting (waiting),
    .expired (expired)
  );

  always_comb begin
    bus.imem_req      = 1'b0;
    bus.dmem_req      = 1'b0;
    bus.dmem_we       = 1'b0;
    bus.dmem_addr_sel = ADDR_ALU;
    ir_write          = 1'b0;
    pc_write          = 1'b0;
    pc_src            = PC_SRC_INC;
    reg_write         = 1'b0;
    wb_sel            = WB_ALU;
    flag_write        = 1'b0;
    sp_dec            = 1'b0;
    sp_inc            = 1'b0;
    illegal_op        = 1'b0;
    bus_error         = 1'b0;
    halted            = 1'b0;
    retire            = 1'b0;

    case (cur_state)
      ST_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end else if (expired) begin
          bus_error = 1'b1;
        end
      end
      ST_DECODE: begin
        if (dec_cls == CLS_NONE) begin
          illegal_op = 1'b1;
          retire     = 1'b1;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_ALU: flag_write = 1'b1;
          CLS_CMP: begin
            flag_write = 1'b1;
            retire     = 1'b1;
          end
          CLS_JMP: begin
            pc_write = cond_true;
            pc_src   = PC_SRC_TARGET;
            retire   = 1'b1;
          end
          CLS_CALL: sp_dec = 1'b1;
          CLS_RET:  bus.dmem_addr_sel = ADDR_SP;
          default: ;
        endcase
      end
      ST_MEM: begin
        bus.dmem_req      = 1'b1;
        bus.dmem_we       = (cls_q == CLS_STR) || (cls_q == CLS_CALL);
        bus.dmem_addr_sel = ((cls_q == CLS_CALL) || (cls_q == CLS_RET)) ? ADDR_SP : ADDR_ALU;
        if (bus.dmem_ready) begin
          if (cls_q == CLS_STR)
            retire = 1'b1;
          if (cls_q == CLS_CALL) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_TARGET;
            retire   = 1'b1;
          end
        end else if (expired) begin
          bus_error = 1'b1;
        end
      end
      ST_WB: begin
        retire = 1'b1;
        case (cls_q)
          CLS_ALU: reg_write = 1'b1;
          CLS_LD: begin
            reg_write = 1'b1;
            wb_sel    = WB_MEM;
          end
          CLS_RET: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_MEM;
            sp_inc   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_FAULT: halted = 1'b1;
      default: ;
    endcase

    // A reset cycle must never commit architectural state.
    if (!reset_n) begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      flag_write = 1'b0;
      sp_dec     = 1'b0;
      sp_inc     = 1'b0;
      illegal_op = 1'b0;
      bus_error  = 1'b0;
      retire     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_state   <= ST_FETCH;
      cls_q       <= CLS_NONE;
      retired_cnt <= '0;
    end else begin
      if (retire)
        retired_cnt <= retired_cnt + 1'b1;
      case (cur_state)
        ST_FETCH: begin
          if (bus.imem_ready)
            cur_state <= ST_DECODE;
          else if (expired)
            cur_state <= ST_FAULT;
        end
        ST_DECODE: begin
          cls_q     <= dec_cls;
          cur_state <= (dec_cls == CLS_NONE) ? ST_FETCH : ST_EXEC;
        end
        ST_EXEC: begin
          case (cls_q)
            CLS_ALU:          cur_state <= ST_WB;
            CLS_CMP, CLS_JMP: cur_state <= ST_FETCH;
            CLS_NONE:         cur_state <= ST_FETCH;
            default:          cur_state <= ST_MEM;
          endcase
        end
        ST_MEM: begin
          if (bus.dmem_ready)
            cur_state <= ((cls_q == CLS_LD) || (cls_q == CLS_RET)) ? ST_WB : ST_FETCH;
          else if (expired)
            cur_state <= ST_FAULT;
        end
        ST_WB:    cur_state <= ST_FETCH;
        ST_FAULT: cur_state <= ST_FAULT;
        default:  cur_state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_multicycle_ctrl;

  localparam int T  = 4;
  localparam int RW = 4;

  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_ALU  = 7'b0000001;
  localparam logic [6:0] F_CMP  = 7'b0000010;
  localparam logic [6:0] F_JMP  = 7'b0000100;
  localparam logic [6:0] F_LD   = 7'b0001000;
  localparam logic [6:0] F_CALL = 7'b0100000;
  localparam logic [6:0] F_RET  = 7'b1000000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [6:0]    flags = '0;
  logic          cond_true = 1'b0;
  logic          ir_write, pc_write, reg_write, wb_sel, flag_write;
  logic          sp_dec, sp_inc, illegal_op, bus_error, halted;
  logic [1:0]    pc_src;
  logic [2:0]    state;
  logic [RW-1:0] retired_cnt;

  multicycle_ctrl_if bus();

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(T), .RET_CNT_W(RW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus.master),
    .is_alu_op   (flags[0]),
    .is_cmp_op   (flags[1]),
    .is_jmp_op   (flags[2]),
    .is_ld_op    (flags[3]),
    .is_str_op   (flags[4]),
    .is_call_op  (flags[5]),
    .is_ret_op   (flags[6]),
    .cond_true   (cond_true),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .wb_sel      (wb_sel),
    .flag_write  (flag_write),
    .sp_dec      (sp_dec),
    .sp_inc      (sp_inc),
    .illegal_op  (illegal_op),
    .bus_error   (bus_error),
    .halted      (halted),
    .state       (state),
    .retired_cnt (retired_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [6:0] f, input logic cnd,
                               input logic ir, input logic dr);
    @(posedge clk);
    #1;
    reset_n        = rst;
    flags          = f;
    cond_true      = cnd;
    bus.imem_ready = ir;
    bus.dmem_ready = dr;
    @(negedge clk);
  endtask

  // Reference model: each class walks a fixed list of phases (phase number =
  // state code); fetch and memory phases advance only on ready.
  typedef struct packed {
    logic       imem_req, ir_write, dmem_req, dmem_we, addr_sel, pc_write;
    logic [1:0] pc_src;
    logic       reg_write, wb_sel, flag_write, sp_dec, sp_inc;
    logic       illegal, berr, halted;
    logic [2:0] st;
  } exp_t;

  int            plen [8] = '{2, 4, 3, 3, 5, 4, 4, 5};
  int            m_idx = 0;
  int            m_cls = 0;
  int            m_wait = 0;
  bit            m_fault = 0;
  bit            m_valid = 0;
  logic [RW-1:0] m_ret = '0;

  function automatic int phase_of(input int cls, input int idx);
    if (idx < 3) return idx;
    if (idx == 3) return (cls == 1) ? 4 : 3;
    return 4;
  endfunction

  function automatic int prio(input logic [6:0] f);
    for (int i = 6; i >= 0; i--)
      if (f[i]) return i + 1;
    return 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   ph;
    e = '0;
    if (m_fault) begin
      e.halted = 1'b1;
      e.st     = 3'd7;
      return e;
    end
    ph   = phase_of(m_cls, m_idx);
    e.st = 3'(ph);
    case (ph)
      0: begin
        e.imem_req = 1'b1;
        if (bus.imem_ready) begin
          e.ir_write = 1'b1;
          e.pc_write = 1'b1;
        end else if (m_wait == T - 1) e.berr = 1'b1;
      end
      1: if (prio(flags) == 0) e.illegal = 1'b1;
      2: begin
        if (m_cls == 1 || m_cls == 2) e.flag_write = 1'b1;
        if (m_cls == 3) begin
          e.pc_write = cond_true;
          e.pc_src   = 2'd1;
        end
        if (m_cls == 6) e.sp_dec = 1'b1;
        if (m_cls == 7) e.addr_sel = 1'b1;
      end
      3: begin
        e.dmem_req = 1'b1;
        e.dmem_we  = (m_cls == 5 || m_cls == 6);
        e.addr_sel = (m_cls == 6 || m_cls == 7);
        if (bus.dmem_ready) begin
          if (m_cls == 6) begin
            e.pc_write = 1'b1;
            e.pc_src   = 2'd1;
          end
        end else if (m_wait == T - 1) e.berr = 1'b1;
      end
      default: begin
        if (m_cls == 1) e.reg_write = 1'b1;
        if (m_cls == 4) begin
          e.reg_write = 1'b1;
          e.wb_sel    = 1'b1;
        end
        if (m_cls == 7) begin
          e.pc_write = 1'b1;
          e.pc_src   = 2'd2;
          e.sp_inc   = 1'b1;
        end
      end
    endcase
    if (!reset_n) begin
      e.ir_write = 0; e.pc_write = 0; e.reg_write = 0; e.flag_write = 0;
      e.sp_dec = 0; e.sp_inc = 0; e.illegal = 0; e.berr = 0;
    end
    return e;
  endfunction

  task automatic model_step();
    int ph;
    bit rdy;
    if (!reset_n) begin
      m_idx = 0; m_wait = 0; m_fault = 0; m_ret = '0; m_valid = 1;
    end else if (m_valid && !m_fault) begin
      ph  = phase_of(m_cls, m_idx);
      rdy = (ph == 0) ? bus.imem_ready : (ph == 3) ? bus.dmem_ready : 1'b1;
      if (!rdy) begin
        if (m_wait == T - 1) m_fault = 1;
        else m_wait++;
      end else begin
        m_wait = 0;
        if (m_idx == 1) m_cls = prio(flags);
        if (m_idx == plen[m_cls] - 1) begin
          m_idx = 0;
          m_ret++;
        end else m_idx++;
      end
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        e = model_out();
        checkOutput("cyc.state",      state,             e.st);
        checkOutput("cyc.imem_req",   bus.imem_req,      e.imem_req);
        checkOutput("cyc.ir_write",   ir_write,          e.ir_write);
        checkOutput("cyc.dmem_req",   bus.dmem_req,      e.dmem_req);
        checkOutput("cyc.dmem_we",    bus.dmem_we,       e.dmem_we);
        checkOutput("cyc.addr_sel",   bus.dmem_addr_sel, e.addr_sel);
        checkOutput("cyc.pc_write",   pc_write,          e.pc_write);
        checkOutput("cyc.pc_src",     pc_src,            e.pc_src);
        checkOutput("cyc.reg_write",  reg_write,         e.reg_write);
        checkOutput("cyc.wb_sel",     wb_sel,            e.wb_sel);
        checkOutput("cyc.flag_write", flag_write,        e.flag_write);
        checkOutput("cyc.sp_dec",     sp_dec,            e.sp_dec);
        checkOutput("cyc.sp_inc",     sp_inc,            e.sp_inc);
        checkOutput("cyc.illegal_op", illegal_op,        e.illegal);
        checkOutput("cyc.bus_error",  bus_error,         e.berr);
        checkOutput("cyc.halted",     halted,            e.halted);
        checkOutput("cyc.retired",    retired_cnt,       m_ret);
      end
      model_step();
    end
  end

  initial begin
    logic [6:0] f;
    int         r;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;

    applyStimulus(0, F_NONE, 0, 1, 1);
    applyStimulus(0, F_NONE, 0, 1, 1);

    // alu, ready tied high: states 0,1,2,4
    applyStimulus(1, F_ALU, 0, 1, 1);
    checkOutput("alu.f.state", state, 0);
    checkOutput("alu.f.ir_write", ir_write, 1);
    checkOutput("alu.f.pc_write", pc_write, 1);
    checkOutput("alu.f.retired", retired_cnt, 0);
    applyStimulus(1, F_ALU, 0, 1, 1);
    checkOutput("alu.d.state", state, 1);
    applyStimulus(1, F_ALU, 0, 1, 1);
    checkOutput("alu.e.state", state, 2);
    checkOutput("alu.e.flag_write", flag_write, 1);
    applyStimulus(1, F_ALU, 0, 1, 1);
    checkOutput("alu.w.state", state, 4);
    checkOutput("alu.w.reg_write", reg_write, 1);
    checkOutput("alu.w.wb_sel", wb_sel, 0);

    // ld with dmem_ready held off for three MEM cycles
    applyStimulus(1, F_LD, 0, 1, 0);
    checkOutput("ld.f.retired", retired_cnt, 1);
    applyStimulus(1, F_LD, 0, 1, 0);
    applyStimulus(1, F_LD, 0, 1, 0);
    checkOutput("ld.e.state", state, 2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, F_LD, 0, 1, (i == 3));
      checkOutput("ld.m.state", state, 3);
      checkOutput("ld.m.dmem_req", bus.dmem_req, 1);
      checkOutput("ld.m.dmem_we", bus.dmem_we, 0);
      checkOutput("ld.m.addr_sel", bus.dmem_addr_sel, 0);
    end
    applyStimulus(1, F_JMP, 0, 1, 1);
    checkOutput("ld.w.state", state, 4);
    checkOutput("ld.w.reg_write", reg_write, 1);
    checkOutput("ld.w.wb_sel", wb_sel, 1);

    // jmp not taken, then taken
    applyStimulus(1, F_JMP, 0, 1, 1);
    checkOutput("jmp0.f.retired", retired_cnt, 2);
    applyStimulus(1, F_JMP, 0, 1, 1);
    applyStimulus(1, F_JMP, 0, 1, 1);
    checkOutput("jmp0.e.pc_write", pc_write, 0);
    applyStimulus(1, F_JMP, 1, 1, 1);
    applyStimulus(1, F_JMP, 1, 1, 1);
    applyStimulus(1, F_JMP, 1, 1, 1);
    checkOutput("jmp1.e.pc_write", pc_write, 1);
    checkOutput("jmp1.e.pc_src", pc_src, 1);

    // call then ret
    applyStimulus(1, F_CALL, 0, 1, 1);
    checkOutput("call.f.retired", retired_cnt, 4);
    applyStimulus(1, F_CALL, 0, 1, 1);
    applyStimulus(1, F_CALL, 0, 1, 1);
    checkOutput("call.e.sp_dec", sp_dec, 1);
    applyStimulus(1, F_CALL, 0, 1, 1);
    checkOutput("call.m.dmem_we", bus.dmem_we, 1);
    checkOutput("call.m.addr_sel", bus.dmem_addr_sel, 1);
    checkOutput("call.m.pc_write", pc_write, 1);
    checkOutput("call.m.pc_src", pc_src, 1);
    applyStimulus(1, F_RET, 0, 1, 1);
    applyStimulus(1, F_RET, 0, 1, 1);
    applyStimulus(1, F_RET, 0, 1, 1);
    checkOutput("ret.e.addr_sel", bus.dmem_addr_sel, 1);
    applyStimulus(1, F_RET, 0, 1, 1);
    checkOutput("ret.m.dmem_we", bus.dmem_we, 0);
    checkOutput("ret.m.addr_sel", bus.dmem_addr_sel, 1);
    applyStimulus(1, F_NONE, 0, 1, 1);
    checkOutput("ret.w.pc_write", pc_write, 1);
    checkOutput("ret.w.pc_src", pc_src, 2);
    checkOutput("ret.w.sp_inc", sp_inc, 1);

    // no class flag set: illegal
    applyStimulus(1, F_NONE, 0, 1, 1);
    checkOutput("ill.f.retired", retired_cnt, 6);
    applyStimulus(1, F_NONE, 0, 1, 1);
    checkOutput("ill.d.illegal_op", illegal_op, 1);
    checkOutput("ill.d.reg_write", reg_write, 0);
    checkOutput("ill.d.pc_write", pc_write, 0);

    // reset while MEM holds dmem_req
    applyStimulus(1, F_LD, 0, 1, 0);
    checkOutput("ill.next.state", state, 0);
    checkOutput("ill.next.retired", retired_cnt, 7);
    applyStimulus(1, F_LD, 0, 1, 0);
    applyStimulus(1, F_LD, 0, 1, 0);
    applyStimulus(1, F_LD, 0, 1, 0);
    checkOutput("rst.m.dmem_req", bus.dmem_req, 1);
    applyStimulus(0, F_LD, 0, 0, 0);
    applyStimulus(1, F_NONE, 0, 0, 0);
    checkOutput("rst.after.state", state, 0);
    checkOutput("rst.after.dmem_req", bus.dmem_req, 0);
    checkOutput("rst.after.retired", retired_cnt, 0);

    // fetch timeout: this is FETCH cycle 1; bus_error lands in cycle 4
    applyStimulus(1, F_NONE, 0, 0, 0);
    applyStimulus(1, F_NONE, 0, 0, 0);
    checkOutput("to.f3.bus_error", bus_error, 0);
    applyStimulus(1, F_NONE, 0, 0, 0);
    checkOutput("to.f4.bus_error", bus_error, 1);
    checkOutput("to.f4.state", state, 0);
    applyStimulus(1, F_NONE, 0, 1, 1);
    checkOutput("to.fault.state", state, 7);
    checkOutput("to.fault.halted", halted, 1);
    checkOutput("to.fault.imem_req", bus.imem_req, 0);
    checkOutput("to.fault.ir_write", ir_write, 0);
    applyStimulus(1, F_NONE, 0, 1, 1);
    checkOutput("to.fault2.state", state, 7);

    // ready arriving in the last budget cycle wins
    applyStimulus(0, F_NONE, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1, F_CMP, 0, (i == 3), 1);
    checkOutput("edge.f4.bus_error", bus_error, 0);
    checkOutput("edge.f4.ir_write", ir_write, 1);
    applyStimulus(1, F_CMP, 0, 1, 1);
    checkOutput("edge.d.state", state, 1);

    // randomized traffic, checked by the per-cycle model compare
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      f = F_NONE;
      else if (r == 1) f = 7'($urandom_range(0, 127));
      else             f = 7'(1 << $urandom_range(0, 6));
      applyStimulus(!(m_fault || ($urandom_range(0, 199) == 0)), f,
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 99) < 65), ($urandom_range(0, 99) < 65));
    end

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
